ncl_dual_rail_counter_link: RTL and testbench

Clocked, parametrised successor of the dual-rail counter ring stage. Generates an N-bit count as dual-rail DATA/NULL wavefronts on a return-to-null 4-phase output link, with a dual-rail carry digit alongside, and waits on consumer completion between wavefronts. Adds selectable width, step, start value and up/down mode. It is the bridge between clocked test harnesses and NCL pipeline consumers.

---
 rtl/ncl_dual_rail_counter_link.sv | 95 +++++++++
 tb/tb_ncl_dual_rail_counter_link.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_dual_rail_counter_link.sv
// Clocked dual-rail counter driving a return-to-null 4-phase link with a dual-rail carry digit.
// Optional completion-protocol checker enabled by defining NCL_LINK_PROTOCOL_CHECK_EN.
module ncl_dual_rail_counter_link #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(1),
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               init,
  input  logic               run,
  input  logic               dir,
  input  logic               out_comp,
  output logic [2*WIDTH-1:0] cnt_dr,
  output logic [1:0]         carry_dr,
  output logic               busy
`ifdef NCL_LINK_PROTOCOL_CHECK_EN
  ,
  output logic               proto_err
`endif
);

  typedef enum logic {StNull, StData} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             dir_q;

  logic [WIDTH:0]     sum_up;
  logic [WIDTH-1:0]   nxt_dn;
  logic               borrow;
  logic [2*WIDTH-1:0] data_dr;

  always_comb begin
    sum_up = {1'b0, count_q} + {1'b0, STEP};
    nxt_dn = count_q - STEP;
    borrow = count_q < STEP;
    data_dr = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      data_dr[2*i]   = ~count_q[i];
      data_dr[2*i+1] = count_q[i];
    end
  end

`ifdef NCL_LINK_PROTOCOL_CHECK_EN
  logic out_comp_q;
`endif

  always_ff @(posedge clk) begin
    if (init) begin
      state_q  <= StNull;
      count_q  <= INIT_VAL;
      dir_q    <= 1'b0;
      cnt_dr   <= '0;
      carry_dr <= 2'b00;
      busy     <= 1'b0;
    end else begin
      unique case (state_q)
        StNull: begin
          // A still-asserted completion means the consumer has not yet seen NULL.
          if (run && !out_comp) begin
            dir_q    <= dir;
            cnt_dr   <= data_dr;
            carry_dr <= (dir ? borrow : sum_up[WIDTH]) ? 2'b10 : 2'b01;
            busy     <= 1'b1;
            state_q  <= StData;
          end
        end
        StData: begin
          if (out_comp) begin
            cnt_dr   <= '0;
            carry_dr <= 2'b00;
            busy     <= 1'b0;
            count_q  <= dir_q ? nxt_dn : sum_up[WIDTH-1:0];
            state_q  <= StNull;
          end
        end
        default: state_q <= StNull;
      endcase
    end

`ifdef NCL_LINK_PROTOCOL_CHECK_EN
    if (init) begin
      out_comp_q <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      out_comp_q <= out_comp;
      if ((state_q == StNull && out_comp && !out_comp_q) ||
          (state_q == StData && !out_comp && out_comp_q)) begin
        proto_err <= 1'b1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_ncl_dual_rail_counter_link.sv
// Bench for ncl_dual_rail_counter_link: three 4-bit instances (up/step1/init0, down/step3/init2,
// up/step1/init3) checked every cycle against a link-level model plus literal launch sequences.
module tb_ncl_dual_rail_counter_link;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       init_s[3];
  logic       run_s[3];
  logic       dir_s[3];
  logic       oc_s[3];
  logic [7:0] cnt_w[3];
  logic [1:0] car_w[3];
  logic       busy_w[3];
`ifdef NCL_LINK_PROTOCOL_CHECK_EN
  logic       perr_w[3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ncl_dual_rail_counter_link #(
      .WIDTH   (W),
      .STEP    (g == 1 ? 4'd3 : 4'd1),
      .INIT_VAL(g == 0 ? 4'd0 : (g == 1 ? 4'd2 : 4'd3))
    ) u_dut (
      .clk     (clk),
      .init    (init_s[g]),
      .run     (run_s[g]),
      .dir     (dir_s[g]),
      .out_comp(oc_s[g]),
      .cnt_dr  (cnt_w[g]),
      .carry_dr(car_w[g]),
      .busy    (busy_w[g])
`ifdef NCL_LINK_PROTOCOL_CHECK_EN
      ,
      .proto_err(perr_w[g])
`endif
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int stepof(int c);
    return (c == 1) ? 3 : 1;
  endfunction

  function automatic int initof(int c);
    return (c == 0) ? 0 : ((c == 1) ? 2 : 3);
  endfunction

  function automatic logic [7:0] enc(int v);
    logic [7:0] r;
    for (int i = 0; i < W; i++) begin
      r[2*i+1] = ((v >> i) & 1) != 0;
      r[2*i]   = !r[2*i+1];
    end
    return r;
  endfunction

  function automatic int dec(logic [7:0] d);
    int v = 0;
    for (int i = 0; i < W; i++) if (d[2*i+1]) v = v | (1 << i);
    return v;
  endfunction

  // Link-level model: presented value, latched direction, carry flag, DATA-present flag.
  int   m_cnt[3];
  logic m_busy[3];
  logic m_dn[3];
  logic m_car[3];

  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (init_s[c]) begin
        m_busy[c] <= 1'b0;
        m_cnt[c]  <= initof(c);
      end else if (!m_busy[c]) begin
        if (run_s[c] && !oc_s[c]) begin
          m_busy[c] <= 1'b1;
          m_dn[c]   <= dir_s[c];
          m_car[c]  <= dir_s[c] ? (m_cnt[c] < stepof(c)) : (m_cnt[c] + stepof(c) >= 16);
        end
      end else if (oc_s[c]) begin
        m_busy[c] <= 1'b0;
        m_cnt[c]  <= m_dn[c] ? (m_cnt[c] - stepof(c) + 16) % 16 : (m_cnt[c] + stepof(c)) % 16;
      end
    end
  end

  typedef struct {
    int         ch;
    logic [7:0] cnt;
    logic [1:0] car;
  } launch_t;

  launch_t lq[$];
  int      nlaunch[3]   = '{0, 0, 0};
  logic    prev_busy[3] = '{1'b0, 1'b0, 1'b0};
  logic    chk_en       = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("busy ch%0d", c), 64'(busy_w[c]), 64'(m_busy[c]));
        chk($sformatf("cnt_dr ch%0d", c), 64'(cnt_w[c]), 64'(m_busy[c] ? enc(m_cnt[c]) : 8'h00));
        chk($sformatf("carry_dr ch%0d", c), 64'(car_w[c]),
            64'(m_busy[c] ? (m_car[c] ? 2'b10 : 2'b01) : 2'b00));
        if (busy_w[c] && !prev_busy[c]) begin
          lq.push_back('{ch: c, cnt: cnt_w[c], car: car_w[c]});
          nlaunch[c]++;
        end
        prev_busy[c] = busy_w[c];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int e0[19];
  int e1[4] = '{2, 15, 12, 9};
  int e2[6] = '{3, 4, 5, 6, 7, 3};
  int idx[3] = '{0, 0, 0};

  initial begin
    for (int c = 0; c < 3; c++) begin
      init_s[c] = 1'b1;
      run_s[c]  = 1'b0;
      dir_s[c]  = 1'b0;
      oc_s[c]   = 1'b0;
    end
    tick();
    chk_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("reset busy", 64'(busy_w[c]), 64'd0);
      chk("reset cnt_dr", 64'(cnt_w[c]), 64'd0);
      chk("reset carry_dr", 64'(car_w[c]), 64'd0);
      init_s[c] = 1'b0;
    end

    // Full up-count wrap on ch0 with a one-cycle consumer.
    run_s[0] = 1'b1;
    for (int k = 0; k < 200 && nlaunch[0] < 17; k++) begin
      tick();
      oc_s[0] = busy_w[0];
    end
    chk("wrap launches", 64'(nlaunch[0]), 64'd17);
    run_s[0] = 1'b0;
    tick();
    oc_s[0] = 1'b0;

    // run low in NULL: nothing launches.
    repeat (10) tick();
    chk("idle busy", 64'(busy_w[0]), 64'd0);
    chk("idle cnt_dr", 64'(cnt_w[0]), 64'd0);
    run_s[0] = 1'b1;
    tick();
    chk("launch after idle", 64'(busy_w[0]), 64'd1);
    for (int k = 0; k < 6; k++) begin
      run_s[0] = k[0];
      dir_s[0] = ~k[1];
      tick();
    end

    // Consumer holds completion after NULL: no relaunch until it drops.
    run_s[0] = 1'b1;
    dir_s[0] = 1'b0;
    oc_s[0]  = 1'b1;
    tick();
    chk("accept to null", 64'(busy_w[0]), 64'd0);
    repeat (5) tick();
    chk("held comp busy", 64'(busy_w[0]), 64'd0);
    oc_s[0] = 1'b0;
    tick();
    chk("relaunch 1 edge", 64'(busy_w[0]), 64'd1);
    chk("relaunch value", 64'(dec(cnt_w[0])), 64'd2);
    oc_s[0] = 1'b1;
    tick();
    oc_s[0] = 1'b0;
    run_s[0] = 1'b0;
    tick();

    // Down count by 3 from 2 on ch1.
    run_s[1] = 1'b1;
    dir_s[1] = 1'b1;
    for (int k = 0; k < 200 && nlaunch[1] < 4; k++) begin
      tick();
      oc_s[1] = busy_w[1];
    end
    chk("down launches", 64'(nlaunch[1]), 64'd4);
    run_s[1] = 1'b0;
    tick();
    oc_s[1] = 1'b0;
    tick();

    // Reset while DATA 7 is held on ch2 (INIT_VAL=3).
    run_s[2] = 1'b1;
    for (int k = 0; k < 200 && nlaunch[2] < 5; k++) begin
      tick();
      oc_s[2] = (nlaunch[2] < 5) ? busy_w[2] : 1'b0;
    end
    tick();
    chk("held 7", 64'(dec(cnt_w[2])), 64'd7);
    init_s[2] = 1'b1;
    tick();
    chk("init busy", 64'(busy_w[2]), 64'd0);
    chk("init cnt_dr", 64'(cnt_w[2]), 64'd0);
    chk("init carry_dr", 64'(car_w[2]), 64'd0);
    init_s[2] = 1'b0;
    tick();
    chk("post-init busy", 64'(busy_w[2]), 64'd1);
    chk("post-init value", 64'(dec(cnt_w[2])), 64'd3);
    oc_s[2] = 1'b1;
    tick();
    oc_s[2]  = 1'b0;
    run_s[2] = 1'b0;
    tick();

`ifdef NCL_LINK_PROTOCOL_CHECK_EN
    chk("perr ch0 clean", 64'(perr_w[0]), 64'd0);
    chk("perr ch2 clean", 64'(perr_w[2]), 64'd0);
    oc_s[1] = 1'b1;
    tick();
    oc_s[1] = 1'b0;
    repeat (3) tick();
    chk("perr sticky", 64'(perr_w[1]), 64'd1);
    init_s[1] = 1'b1;
    tick();
    init_s[1] = 1'b0;
    chk("perr cleared", 64'(perr_w[1]), 64'd0);
`endif

    // Literal launch sequences.
    for (int k = 0; k < 19; k++) e0[k] = (k < 17) ? k % 16 : k - 16;
    foreach (lq[i]) begin
      int c;
      int v;
      c = lq[i].ch;
      v = dec(lq[i].cnt);
      if (c == 0 && idx[0] < 19) begin
        chk($sformatf("seq0[%0d]", idx[0]), 64'(v), 64'(e0[idx[0]]));
        chk($sformatf("car0[%0d]", idx[0]), 64'(lq[i].car),
            64'((idx[0] == 15) ? 2'b10 : 2'b01));
        if (idx[0] == 5) chk("enc 5", 64'(lq[i].cnt), 64'(8'b01100110));
      end else if (c == 1 && idx[1] < 4) begin
        chk($sformatf("seq1[%0d]", idx[1]), 64'(v), 64'(e1[idx[1]]));
        chk($sformatf("car1[%0d]", idx[1]), 64'(lq[i].car),
            64'((idx[1] == 0) ? 2'b10 : 2'b01));
      end else if (c == 2 && idx[2] < 6) begin
        chk($sformatf("seq2[%0d]", idx[2]), 64'(v), 64'(e2[idx[2]]));
        chk($sformatf("car2[%0d]", idx[2]), 64'(lq[i].car), 64'(2'b01));
      end
      idx[c]++;
    end
    chk("count ch0", 64'(nlaunch[0]), 64'd19);
    chk("count ch1", 64'(nlaunch[1]), 64'd4);
    chk("count ch2", 64'(nlaunch[2]), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
